// File: rtl/calc_pkg.sv
// Shared types for the multi-port calculator engine: command/response encodings,
// capture FSM states and the queued request entry.
package calc_pkg;

  localparam int unsigned CmdW     = 4;
  localparam int unsigned MaxDataW = 64;
  localparam int unsigned MaxTagW  = 8;

  typedef enum logic [CmdW-1:0] {
    CmdNop = 4'd0,
    CmdAdd = 4'd1,
    CmdSub = 4'd2,
    CmdShl = 4'd5,
    CmdShr = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RespNone = 2'd0,
    RespOk   = 2'd1,
    RespErr  = 2'd2
  } resp_e;

  typedef enum logic {
    StIdle = 1'b0,
    StOp2  = 1'b1
  } cap_state_e;

  // Sized for the widest legal configuration; the engine zero-extends into it.
  typedef struct packed {
    logic [CmdW-1:0]     cmd;
    logic [MaxTagW-1:0]  tag;
    logic [MaxDataW-1:0] op1;
    logic [MaxDataW-1:0] op2;
  } req_entry_t;

endpackage

// File: rtl/calc_port_fifo.sv
// Per-port synchronous request queue with occupancy count.
// The producer never pushes while full, so push is not guarded here.
module calc_port_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             pop_ok;

  always_comb begin
    pop_ok  = pop_i && (count_q != '0);
    count_d = count_q;
    if (push_i && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_ok) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/calc_nport_engine.sv
// N-port calculator: per-port two-cycle command capture into a queue, round-robin
// arbitration, then a grant / ALU / response pipeline back to the originating port.
module calc_nport_engine
  import calc_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                ifClk,
  input  logic                                ifRst,
  input  logic [NUM_PORTS-1:0][CmdW-1:0]      ifReq_cmd_in,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    ifReq_data_in,
  input  logic [NUM_PORTS-1:0][TAG_W-1:0]     ifReq_tag_in,
  output logic [NUM_PORTS-1:0]                ifReq_ready,
  output logic [NUM_PORTS-1:0][1:0]           ifResp_out,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]    ifData_out,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]     ifTag_out
);

  localparam int unsigned PortW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned ShW    = $clog2(DATA_W);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntryW = $bits(req_entry_t);

  cap_state_e [NUM_PORTS-1:0]              state_q, state_d;
  logic       [NUM_PORTS-1:0][CmdW-1:0]    cmd_q;
  logic       [NUM_PORTS-1:0][TAG_W-1:0]   tag_q;
  logic       [NUM_PORTS-1:0][DATA_W-1:0]  op1_q;
  logic       [NUM_PORTS-1:0]              accept, push, pop, fifo_empty;
  logic       [NUM_PORTS-1:0][CntW-1:0]    fifo_cnt;
  req_entry_t [NUM_PORTS-1:0]              push_entry, fifo_rdata;

  logic             grant_valid;
  logic [PortW-1:0] grant_idx, rr_ptr_q, rr_ptr_d;

  logic             s1_valid_q, s2_valid_q;
  logic [PortW-1:0] s1_port_q, s2_port_q;
  req_entry_t       s1_entry_q;
  resp_e            s2_resp_q, alu_resp;
  logic [DATA_W-1:0] s2_data_q, alu_a, alu_b, alu_data;
  logic [TAG_W-1:0] s2_tag_q;
  logic [DATA_W:0]  alu_sum;
  logic [ShW-1:0]   alu_sh;
  logic             unused_entry;

  // Capture FSM: state register
  always_ff @(posedge ifClk or negedge ifRst) begin
    if (!ifRst) begin
      for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture FSM: next state
  always_comb begin
    state_d = state_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      unique case (state_q[p])
        StIdle:  if (accept[p]) state_d[p] = StOp2;
        StOp2:   state_d[p] = StIdle;
        default: state_d[p] = StIdle;
      endcase
    end
  end

  // Capture FSM: outputs; op2 is taken straight from the bus in the push cycle
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      ifReq_ready[p] = (state_q[p] == StIdle) && (fifo_cnt[p] < CntW'(FIFO_DEPTH));
      accept[p]      = ifReq_ready[p] && (ifReq_cmd_in[p] != CmdNop);
      push[p]        = (state_q[p] == StOp2);
      push_entry[p]  = '{cmd: cmd_q[p],
                         tag: MaxTagW'(tag_q[p]),
                         op1: MaxDataW'(op1_q[p]),
                         op2: MaxDataW'(ifReq_data_in[p])};
    end
  end

  always_ff @(posedge ifClk or negedge ifRst) begin
    if (!ifRst) begin
      cmd_q <= '0;
      tag_q <= '0;
      op1_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[p]) begin
          cmd_q[p] <= ifReq_cmd_in[p];
          tag_q[p] <= ifReq_tag_in[p];
          op1_q[p] <= ifReq_data_in[p];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc_port_fifo #(
      .Width (EntryW),
      .Depth (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (ifClk),
      .rst_ni  (ifRst),
      .push_i  (push[p]),
      .wdata_i (push_entry[p]),
      .pop_i   (pop[p]),
      .rdata_o (fifo_rdata[p]),
      .empty_o (fifo_empty[p]),
      .count_o (fifo_cnt[p])
    );
  end

  // Round-robin: first non-empty queue at or after the pointer
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_PORTS;
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PortW'(idx);
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      pop[p] = grant_valid && (grant_idx == PortW'(p));
    end
  end

  always_comb begin
    alu_a    = s1_entry_q.op1[DATA_W-1:0];
    alu_b    = s1_entry_q.op2[DATA_W-1:0];
    alu_sh   = alu_b[ShW-1:0];
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    alu_resp = RespOk;
    alu_data = '0;
    case (cmd_e'(s1_entry_q.cmd))
      CmdAdd: begin
        if (alu_sum[DATA_W]) alu_resp = RespErr;
        else                 alu_data = alu_sum[DATA_W-1:0];
      end
      CmdSub: begin
        if (alu_b > alu_a) alu_resp = RespErr;
        else               alu_data = alu_a - alu_b;
      end
      CmdShl:  alu_data = alu_a << alu_sh;
      CmdShr:  alu_data = alu_a >> alu_sh;
      default: alu_resp = RespErr;
    endcase
  end

  // Upper entry bits beyond DATA_W/TAG_W are zero padding
  assign unused_entry = ^s1_entry_q;

  always_ff @(posedge ifClk or negedge ifRst) begin
    if (!ifRst) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_port_q  <= '0;
      s1_entry_q <= '0;
      s2_valid_q <= 1'b0;
      s2_port_q  <= '0;
      s2_resp_q  <= RespNone;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= grant_valid;
      s1_port_q  <= grant_idx;
      s1_entry_q <= fifo_rdata[grant_idx];
      s2_valid_q <= s1_valid_q;
      s2_port_q  <= s1_port_q;
      s2_resp_q  <= alu_resp;
      s2_data_q  <= alu_data;
      s2_tag_q   <= s1_entry_q.tag[TAG_W-1:0];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      ifResp_out[p] = RespNone;
      ifData_out[p] = '0;
      ifTag_out[p]  = '0;
      if (s2_valid_q && (s2_port_q == PortW'(p))) begin
        ifResp_out[p] = s2_resp_q;
        ifData_out[p] = s2_data_q;
        ifTag_out[p]  = s2_tag_q;
      end
    end
  end

endmodule
